// File: rtl/ccx_ic_sram.sv
// ccx_ic_sram: memory-side target for the core complex interconnect RAM port.
// Turns the core_mem_bus request/response stream into accesses on a
// single-port synchronous SRAM macro (one-cycle read latency). Requests are
// range-checked against BASE, writes are byte-strobed, and responses are
// returned in order through a small FIFO that absorbs response backpressure.
//
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   mem_req/mem_gnt         request handshake (accept = mem_req && mem_gnt)
//   mem_wen/strb/addr/wdata request payload
//   mem_recv/mem_ack        response handshake (pop = mem_recv && mem_ack)
//   mem_error/mem_rdata     response payload from the FIFO head (0 when empty)
//   sram_*                  SRAM macro interface; sram_rdata valid one cycle
//                           after a read select
module ccx_ic_sram #(
    parameter int unsigned   AW        = 39,
    parameter int unsigned   DW        = 64,
    parameter int unsigned   DEPTH     = 8192,
    parameter logic [AW-1:0] BASE      = AW'(32'h0001_0000),
    parameter int unsigned   RSP_DEPTH = 3
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     mem_req,
    output logic                     mem_gnt,
    input  logic                     mem_wen,
    input  logic [DW/8-1:0]          mem_strb,
    input  logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_wdata,
    output logic                     mem_recv,
    input  logic                     mem_ack,
    output logic                     mem_error,
    output logic [DW-1:0]            mem_rdata,
    output logic                     sram_cs,
    output logic                     sram_wen,
    output logic [DW/8-1:0]          sram_bwe,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [DW-1:0]            sram_wdata,
    input  logic [DW-1:0]            sram_rdata
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned OFFW = $clog2(SW);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned TAGW = AW - OFFW - IDXW;
    localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);

    localparam logic [TAGW-1:0] BASE_TAG = BASE[AW-1:OFFW+IDXW];

    // Accepted-but-not-popped transactions and the grant derived from it
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic          gnt_q;

    // In-flight record for the access issued to the SRAM last cycle
    logic          s1_valid_q;
    logic          s1_err_q;
    logic          s1_read_q;

    // Response FIFO
    logic [DW-1:0] fifo_data_q [RSP_DEPTH];
    logic          fifo_err_q  [RSP_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] fifo_cnt_q;

    logic          in_range_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;
    logic          fifo_empty_c;
    logic [DW-1:0] push_data_c;
    logic          unused_addr_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request decode and handshakes; inputs are ignored while in reset
    assign in_range_c    = (mem_addr[AW-1:OFFW+IDXW] == BASE_TAG);
    assign accept_c      = !g_reset && mem_req && gnt_q;
    assign fifo_empty_c  = (fifo_cnt_q == '0);
    assign pop_c         = !g_reset && !fifo_empty_c && mem_ack;
    assign push_c        = s1_valid_q;
    assign unused_addr_c = ^mem_addr[OFFW-1:0];

    // Writes and out-of-range accesses return zero data
    assign push_data_c = (s1_read_q && !s1_err_q) ? sram_rdata : '0;

    // Outstanding count next value
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_c && !pop_c) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!accept_c && pop_c) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // Grant and in-flight stage; the grant is a pure register so there is
    // no combinational path from mem_ack or mem_req to mem_gnt
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            outstanding_q <= '0;
            gnt_q         <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_read_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            gnt_q         <= (outstanding_d < CW'(RSP_DEPTH));
            s1_valid_q    <= accept_c;
            s1_err_q      <= !in_range_c;
            s1_read_q     <= !mem_wen;
        end
    end

    // FIFO pointers and occupancy; the grant limit rules out overflow
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_c && !pop_c) begin
                fifo_cnt_q <= fifo_cnt_q + CW'(1);
            end else if (!push_c && pop_c) begin
                fifo_cnt_q <= fifo_cnt_q - CW'(1);
            end
        end
    end

    // FIFO storage; contents are qualified by occupancy so need no reset
    always_ff @(posedge g_clk) begin
        if (push_c) begin
            fifo_data_q[wr_ptr_q] <= push_data_c;
            fifo_err_q[wr_ptr_q]  <= s1_err_q;
        end
    end

    assign mem_gnt   = gnt_q;
    assign mem_recv  = !fifo_empty_c;
    assign mem_error = !fifo_empty_c && fifo_err_q[rd_ptr_q];
    assign mem_rdata = fifo_empty_c ? '0 : fifo_data_q[rd_ptr_q];

    // SRAM drive straight from the accepted request
    assign sram_cs    = accept_c && in_range_c;
    assign sram_wen   = !g_reset && mem_wen;
    assign sram_bwe   = sram_wen ? mem_strb : '0;
    assign sram_addr  = mem_addr[OFFW+IDXW-1:OFFW];
    assign sram_wdata = mem_wdata;

endmodule

// File: tb/tb_ccx_ic_sram.sv
// Testbench for ccx_ic_sram: directed steps followed by a randomized phase,
// every cycle compared against a transaction-level reference model
// (byte-addressed word store plus an in-order queue of expected responses).
module tb_ccx_ic_sram;

    localparam logic [38:0] BASE = 39'h0001_0000;
    localparam logic [38:0] SPAN = 39'h0001_0000;

    logic        g_clk;
    logic        g_reset;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [38:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [63:0] mem_rdata;
    logic        sram_cs;
    logic        sram_wen;
    logic [7:0]  sram_bwe;
    logic [12:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    ccx_ic_sram dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .sram_cs    (sram_cs),
        .sram_wen   (sram_wen),
        .sram_bwe   (sram_bwe),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // SRAM macro: byte-write, one-cycle read latency, unwritten words read 0
    logic [63:0] sram_mem [int];
    logic [63:0] sram_w;
    always @(posedge g_clk) begin
        if (sram_cs) begin
            sram_w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 64'h0;
            if (sram_wen) begin
                for (int b = 0; b < 8; b++)
                    if (sram_bwe[b]) sram_w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                sram_mem[int'(sram_addr)] = sram_w;
            end else begin
                sram_rdata <= sram_w;
            end
        end
    end

    // Reference model
    typedef struct {
        int          ready;
        logic        err;
        logic [63:0] data;
    } rsp_t;

    rsp_t        rsp_q [$];
    logic [63:0] ref_mem [int];
    int          cyc;
    int          n_cmp;
    int          n_fail;
    int          n_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [38:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic int word_of(input logic [38:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // One bus cycle: drive, check everything against the model, advance
    task automatic step(input logic req, input logic wen, input logic [7:0] strb,
                        input logic [38:0] addr, input logic [63:0] wdata,
                        input logic ack, output logic acc);
        logic        rng;
        logic        exp_gnt;
        logic        exp_recv;
        logic        exp_err;
        logic [63:0] exp_data;
        logic [63:0] old;
        logic [63:0] nw;
        rsp_t        r;
        int          idx;
        mem_req   = req;
        mem_wen   = wen;
        mem_strb  = strb;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_ack   = ack;
        #1;
        rng      = in_win(addr);
        exp_gnt  = (rsp_q.size() < 3);
        exp_recv = (rsp_q.size() > 0) && (rsp_q[0].ready <= cyc);
        exp_err  = exp_recv ? rsp_q[0].err  : 1'b0;
        exp_data = exp_recv ? rsp_q[0].data : 64'h0;
        chk("gnt",   64'(mem_gnt),   64'(exp_gnt));
        chk("recv",  64'(mem_recv),  64'(exp_recv));
        chk("error", 64'(mem_error), 64'(exp_err));
        chk("rdata", mem_rdata, exp_data);
        acc = req && mem_gnt;
        chk("sram_cs", 64'(sram_cs), 64'(acc && rng));
        if (acc && rng) begin
            chk("sram_addr", 64'(sram_addr), 64'(word_of(addr)));
            chk("sram_wen",  64'(sram_wen),  64'(wen));
            chk("sram_bwe",  64'(sram_bwe),  wen ? 64'(strb) : 64'h0);
            if (wen) chk("sram_wdata", sram_wdata, wdata);
        end
        if (mem_recv && ack) n_pop++;
        if (exp_recv && ack) void'(rsp_q.pop_front());
        if (acc) begin
            r.ready = cyc + 2;
            r.err   = !rng;
            r.data  = 64'h0;
            if (rng) begin
                idx = word_of(addr);
                old = ref_mem.exists(idx) ? ref_mem[idx] : 64'h0;
                if (wen) begin
                    nw = old;
                    for (int b = 0; b < 8; b++)
                        if (strb[b]) nw[b*8 +: 8] = wdata[b*8 +: 8];
                    ref_mem[idx] = nw;
                end else begin
                    r.data = old;
                end
            end
            rsp_q.push_back(r);
        end
        @(posedge g_clk);
        @(negedge g_clk);
        cyc++;
    endtask

    task automatic xfer(input logic wen, input logic [7:0] strb,
                        input logic [38:0] addr, input logic [63:0] wdata);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++)
            step(1'b1, wen, strb, addr, wdata, 1'b1, acc);
        if (!acc) chk("xfer_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n, input logic ack);
        logic acc;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 8'h00, BASE, 64'h0, ack, acc);
    endtask

    task automatic do_reset();
        g_reset   = 1'b1;
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_strb  = 8'hFF;
        mem_addr  = BASE;
        mem_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        mem_ack   = 1'b1;
        #1;
        chk("rst_sram_cs",  64'(sram_cs),  64'(0));
        chk("rst_sram_wen", 64'(sram_wen), 64'(0));
        chk("rst_sram_bwe", 64'(sram_bwe), 64'(0));
        @(posedge g_clk);
        @(negedge g_clk);
        cyc++;
        rsp_q.delete();
        g_reset = 1'b0;
        mem_req = 1'b0;
        mem_wen = 1'b0;
        #1;
        chk("rst_recv",  64'(mem_recv),  64'(0));
        chk("rst_gnt",   64'(mem_gnt),   64'(1));
        chk("rst_error", 64'(mem_error), 64'(0));
        chk("rst_rdata", mem_rdata, 64'h0);
    endtask

    initial begin
        logic        acc;
        logic [38:0] a;
        int          k;
        int          n_acc;
        cyc    = 0;
        n_cmp  = 0;
        n_fail = 0;
        n_pop  = 0;
        g_reset   = 1'b1;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_strb  = 8'h00;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ack   = 1'b0;
        @(negedge g_clk);
        do_reset();
        @(negedge g_clk);
        cyc++;

        // Write then read
        xfer(1'b1, 8'hFF, 39'h10008, 64'hDEADBEEF_CAFEF00D);
        idle(3, 1'b1);
        xfer(1'b0, 8'h00, 39'h10008, 64'h0);
        idle(3, 1'b1);

        // Partial strobe, then zero strobe leaves the word untouched
        xfer(1'b1, 8'h0F, 39'h10008, 64'h11111111_22222222);
        xfer(1'b0, 8'h00, 39'h10008, 64'h0);
        xfer(1'b1, 8'h00, 39'h10008, 64'h55555555_55555555);
        xfer(1'b0, 8'h00, 39'h10008, 64'h0);
        idle(3, 1'b1);

        // Out of range read and write; word 0 must stay unwritten
        xfer(1'b0, 8'h00, 39'h20000, 64'h0);
        xfer(1'b1, 8'hFF, 39'h00000, 64'hFFFFFFFF_FFFFFFFF);
        xfer(1'b0, 8'h00, 39'h10000, 64'h0);
        idle(3, 1'b1);

        // Backpressure
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 8'hFF, BASE + 39'(8 * (4 + i)), 64'hA000_0000_0000_0000 + 64'(i));
        idle(3, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'h00, BASE + 39'(8 * (4 + i)), 64'h0, 1'b0, acc);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'h00, BASE + 39'(8 * 7), 64'h0, 1'b0, acc);
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 10) begin
            step(1'b1, 1'b0, 8'h00, BASE + 39'(8 * 7), 64'h0, 1'b1, acc);
            k++;
        end
        chk("bp_regrant_cycle", 64'(k), 64'(2));
        idle(6, 1'b1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 39'(32'h20000 + 8 * $urandom_range(0, 15)) : 39'(8 * $urandom_range(0, 15));
            else
                a = BASE + 39'(8 * $urandom_range(0, 15) + $urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 a, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(8, 1'b1);

        // Streaming
        n_acc = 0;
        n_pop = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'h00, BASE + 39'(8 * i), 64'h0, 1'b1, acc);
            if (acc) n_acc++;
        end
        idle(2, 1'b1);
        chk("stream_accepts",   64'(n_acc), 64'(16));
        chk("stream_responses", 64'(n_pop), 64'(16));
        idle(2, 1'b1);

        // Reset with two responses outstanding
        step(1'b1, 1'b0, 8'h00, 39'h10008, 64'h0, 1'b0, acc);
        step(1'b1, 1'b0, 8'h00, 39'h10010, 64'h0, 1'b0, acc);
        do_reset();
        n_pop = 0;
        idle(5, 1'b1);
        chk("no_stale_rsp", 64'(n_pop), 64'(0));
        xfer(1'b0, 8'h00, 39'h10008, 64'h0);
        xfer(1'b0, 8'h00, 39'h10020, 64'h0);
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ccx_ic_sram.md
Name: ccx_ic_sram

Overview:
- Memory-side target for the core complex interconnect RAM port. It consumes the core_mem_bus request/response stream produced by the RAM arbiter and drives a single-port synchronous SRAM macro (one-cycle read latency).
- Provides address range checking, byte-strobed writes and a response FIFO. Supports in-order, back-to-back transactions at one per cycle with response backpressure.

Parameters:
- AW, 39, address width.
- DW, 64, data width; must be a power of two ≥ 32.
- DEPTH, 8192, SRAM depth in DW-bit words; must be a power of two.
- BASE, 'h00010000, byte base address; aligned to DEPTH*DW/8.
- RSP_DEPTH, 3, response FIFO entries = maximum outstanding transactions.

Derived widths: OFFW = clog2(DW/8); IDXW = clog2(DEPTH).

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous active-high reset.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted when mem_req && mem_gnt.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  DW/8  write byte strobes.
- mem_addr  in  AW  byte address.
- mem_wdata  in  DW  write data.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response consumed when mem_recv && mem_ack.
- mem_error  out  1  response error flag.
- mem_rdata  out  DW  response read data.
- sram_cs  out  1  SRAM chip select, active high.
- sram_wen  out  1  SRAM write enable.
- sram_bwe  out  DW/8  SRAM byte write enables.
- sram_addr  out  IDXW  SRAM word index.
- sram_wdata  out  DW  SRAM write data.
- sram_rdata  in  DW  SRAM read data, valid the cycle after a read select.

Behaviour:
- Clock is g_clk; reset is g_reset, synchronous, active-high. One clock domain.
- **Reset values:**
  - mem_gnt = 1, mem_recv = 0, mem_error = 0, mem_rdata = 0.
  - sram_cs = 0, sram_wen = 0, sram_bwe = 0.
  - FIFO empty, outstanding counter = 0, in-flight flag = 0.
- **Outstanding counter:**
  - Increments on request accept; decrements on response handshake; both in the same cycle leave it unchanged.
  - Range 0..RSP_DEPTH.
- **Grant:** mem_gnt = (outstanding < RSP_DEPTH). It is registered-state-only: no combinational path from mem_ack or mem_req.
- **Decode:**
  - in_range = mem_addr[AW-1:OFFW+IDXW] == BASE[AW-1:OFFW+IDXW].
  - sram_addr = mem_addr[OFFW+IDXW-1:OFFW]. Low OFFW bits are ignored.
- **SRAM drive on accept (combinational from the request):**
  - sram_cs = mem_req && mem_gnt && in_range.
  - sram_wen = mem_wen.
  - sram_bwe = mem_wen ? mem_strb : 0.
  - sram_wdata = mem_wdata.
  - Out-of-range requests never assert sram_cs.
- **Pipeline:**
  - Stage 1 (accept cycle N): the SRAM is accessed at the end of N. An in-flight record {error = !in_range, is_read} is registered.
  - Stage 2 (cycle N+1): the FIFO entry is written at the end of N+1.
    - Read, in range: data = sram_rdata, error = 0.
    - Write, or out of range: data = 0.
    - error = recorded error.
  - mem_recv rises in cycle N+2. Fixed latency is 2 cycles from accept to first visible response when the FIFO is empty.
- **Ordering and response stability:**
  - Responses are strictly in order.
  - While mem_recv && !mem_ack, the values of mem_error and mem_rdata are held stable.
  - mem_rdata and mem_error come from the FIFO head and are 0 when the FIFO is empty.
- **FIFO:**
  - Circular buffer of RSP_DEPTH entries with read/write pointers that wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - The grant limit guarantees no overflow.
- **Throughput:** with RSP_DEPTH = 3 and mem_ack held high, one transaction per cycle is sustained indefinitely.
- **Writes:** the response is still returned (error = 0, rdata = 0) after the write has been committed to the SRAM.
- **Strobes:** strb = 0 on a write is legal. The access is performed with no bytes written and a normal response is returned.
- **Reset mid-operation:**
  - Discards all in-flight and buffered responses; the next cycle has mem_recv = 0 and mem_gnt = 1.
  - SRAM contents are not cleared.
- Inputs are ignored while g_reset = 1.

Test Plan:
1. **Write then read.** Write addr 'h10008, strb 'hFF, wdata 'hDEADBEEF_CAFEF00D (accept cycle N) → mem_recv in N+2 with error 0. Then read 'h10008 → rdata 'hDEADBEEF_CAFEF00D, error 0, 2 cycles after accept.
2. **Partial strobe.** Following test 1, write 'h10008 with strb 'h0F, wdata 'h11111111_22222222 → read returns 'hDEADBEEF_22222222.
3. **Out of range.** Read 'h00020000 → sram_cs never asserted, response error 1, rdata 0. A write to 'h0 gives the same result and SRAM is unmodified.
4. **Backpressure.** Hold mem_ack = 0 and present 4 reads back-to-back → 3 accepted, then mem_gnt = 0. The head response stays stable over 5 cycles. Raising mem_ack drains the responses in address order, and the 4th request is granted the cycle after the first pop.
5. **Streaming.** 16 reads to consecutive words with mem_ack = 1 → 16 accepts in 16 consecutive cycles, and 16 in-order responses in 16 consecutive cycles starting at accept + 2.
6. **Reset mid-operation.** Pulse g_reset for 1 cycle with 2 responses outstanding → mem_recv = 0 and mem_gnt = 1 the next cycle, no stale responses appear afterwards, and earlier written data still reads back correctly.
